fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control unit.
- Holds the PC and issues a valid/ready request to instruction memory, then latches the returned word.
- Presents the Op, Funct3 and Funct7b5 fields to the decoder and holds them until the execute side commits.
- On commit, advances the PC to PC+4, or to PCTarget when PCSrc is high.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_unit_pc_next_sel.sv | 22 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, NOP word and decode field positions for the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;
    localparam int          OP_LSB      = 0;
    localparam int          OP_MSB      = 6;
    localparam int          F3_LSB      = 12;
    localparam int          F3_MSB      = 14;
    localparam int          F7B5_BIT    = 30;
endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel: sequential/redirect next-PC select; misalignment compare under FETCH_MISALIGN_CHECK_EN.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);
    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);
    assign pc_next  = PCSrc ? PCTarget : pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = PCSrc && (PCTarget[1:0] != 2'b00);
`endif
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, valid/ready imem request and held instruction for decode.
// Optional FETCH_MISALIGN_CHECK_EN adds fetch_fault and a terminal HALT state on misaligned redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            commit,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      Op,
    output logic [2:0]      Funct3,
    output logic            Funct7b5
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);
    state_t          state, state_next;
    logic [XLEN-1:0] pc_next;
    logic            halt_go;
    logic            take_rsp;
    logic            take_commit;

    assign take_rsp    = (state == WAIT) && imem_rsp_valid;
    assign take_commit = (state == HOLD) && commit;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    assign halt_go = misaligned;
`else
    assign halt_go = 1'b0;
`endif

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc       (pc),
        .PCSrc    (PCSrc),
        .PCTarget (PCTarget),
        .pc_plus4 (pc_plus4),
        .pc_next  (pc_next)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = ((state == FETCH) && imem_req_ready) ? WAIT :
                     take_rsp                             ? HOLD :
                     take_commit                          ? (halt_go ? HALT : FETCH) :
                                                            state;
    end

    always_comb begin
        imem_req_valid = (state == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (take_rsp) begin
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
        end else if (take_commit) begin
            pc          <= pc_next;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       fetch_fault <= 1'b0;
        else if (take_commit && misaligned) fetch_fault <= 1'b1;
    end
`endif

    assign imem_addr = pc;
    assign Op        = instr[OP_MSB:OP_LSB];
    assign Funct3    = instr[F3_MSB:F3_LSB];
    assign Funct7b5  = instr[F7B5_BIT];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (also covers FETCH_MISALIGN_CHECK_EN when defined).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        commit;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  Op;
    logic [2:0]  Funct3;
    logic        Funct7b5;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .commit         (commit),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .Op             (Op),
        .Funct3         (Funct3),
        .Funct7b5       (Funct7b5)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_no_req", imem_req_valid, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        check("latched_valid", instr_valid, 1'b1);
        check("latched_instr", instr, word);
    endtask

    task automatic do_commit(input logic src, input logic [31:0] tgt);
        commit   = 1'b1;
        PCSrc    = src;
        PCTarget = tgt;
        tick();
        commit   = 1'b0;
        PCSrc    = 1'b1;
        PCTarget = 32'hDEAD_BEE0;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        commit = 1'b0;
        PCSrc = 1'b0;
        PCTarget = 32'h0;
        repeat (2) tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_op", Op, 7'b0010011);
        check("rst_req", imem_req_valid, 1'b1);
        rst_n = 1'b1;
        tick();
        check("first_req", imem_req_valid, 1'b1);
        check("first_addr", imem_addr, 32'h0);

        do_fetch(32'h0000_0033);
        check("add_op", Op, 7'b0110011);
        check("add_f3", Funct3, 3'd0);
        check("pc_plus4_0", pc_plus4, 32'h4);

        do_commit(1'b0, 32'h0000_0100);
        check("seq_req", imem_req_valid, 1'b1);
        check("seq_addr", imem_addr, 32'h4);
        check("seq_clr_valid", instr_valid, 1'b0);
        check("seq_clr_op", Op, 7'b0010011);

        for (int i = 0; i < 5; i++) begin
            imem_rsp_valid = (i == 2);
            imem_rsp_data  = 32'hBAD0_0BAD;
            tick();
            check("stall_req", imem_req_valid, 1'b1);
            check("stall_addr", imem_addr, 32'h4);
        end
        imem_rsp_valid = 1'b0;
        check("fetch_rsp_drop", instr, 32'h0000_0013);

        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        commit = 1'b1;
        PCSrc  = 1'b1;
        PCTarget = 32'h0000_0200;
        tick();
        commit = 1'b0;
        PCSrc  = 1'b0;
        check("wait_commit_pc", pc, 32'h4);
        check("wait_commit_noreq", imem_req_valid, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h4000_5033;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_1111;
        tick();
        imem_rsp_valid = 1'b0;
        check("hold_rsp_drop", instr, 32'h4000_5033);
        check("sra_f3", Funct3, 3'd5);
        check("sra_f7b5", Funct7b5, 1'b1);
        check("sra_op", Op, 7'b0110011);

        PCSrc = 1'b1;
        PCTarget = 32'h0000_0300;
        tick();
        check("no_commit_pc", pc, 32'h4);
        check("no_commit_valid", instr_valid, 1'b1);
        do_commit(1'b1, 32'h0000_0040);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_req", imem_req_valid, 1'b1);

        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_pc40", pc, 32'h40);
        rst_n = 1'b0;
        #2;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_req", imem_req_valid, 1'b1);
        tick();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        tick();
        imem_rsp_valid = 1'b0;
        check("stale_valid", instr_valid, 1'b0);
        check("stale_instr", instr, 32'h0000_0013);
        check("fresh_req", imem_req_valid, 1'b1);
        check("fresh_addr", imem_addr, 32'h0);

        do_fetch(32'h0000_0013);
        do_commit(1'b1, 32'hFFFF_FFFC);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0013);
        check("wrap_plus4", pc_plus4, 32'h0);
        do_commit(1'b0, 32'h0000_0500);
        check("wrap_addr", imem_addr, 32'h0);

        do_fetch(32'h0000_0013);
        do_commit(1'b1, 32'h0000_0042);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("fault_set", fetch_fault, 1'b1);
        check("fault_pc", pc, 32'h42);
        imem_req_ready = 1'b1;
        repeat (3) tick();
        check("halt_noreq", imem_req_valid, 1'b0);
        check("halt_valid", instr_valid, 1'b0);
        check("fault_sticky", fetch_fault, 1'b1);
        imem_req_ready = 1'b0;
`else
        check("misalign_addr", imem_addr, 32'h42);
        check("misalign_req", imem_req_valid, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
